scan_mux_reg: RTL and testbench
===============================

# scan_mux_reg

Parametrised, registered N-to-1 word multiplexer with a valid/ready output stage and an automatic scan mode. It generalises the team's fixed 16-bit, 32-input combinational mux:

- **Manual mode:** one selected input per cycle.
- **Scan mode:** after a `start` pulse, streams every input in index order 0..N-1 and then signals `done`.

It sits between a bank of parallel data sources and a single serial consumer, for example a display or a UART framer.

## Interface
Parameters:
- `WIDTH`, 16: bits per input word.
- `N`, 32: number of inputs; N ≥ 2, need not be a power of two.
- `SEL_W`, `$clog2(N)`: select/index width; derived, not overridden.

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `din`, in, N*WIDTH: flattened inputs; input i occupies bits `[i*WIDTH +: WIDTH]`.
- `sel`, in, SEL_W: manual-mode select.
- `mode`, in, 1: 0 = manual, 1 = scan. Sampled only in IDLE.
- `start`, in, 1: begins a scan. Honoured only in IDLE with `mode`=1.
- `d`, out, WIDTH: registered output word.
- `d_idx`, out, SEL_W: index of the input held in `d`.
- `d_valid`, out, 1: `d`/`d_idx` hold an unconsumed beat.
- `d_ready`, in, 1: consumer accepts the beat on any edge where `d_valid`=1.
- `busy`, out, 1: high in SCAN and DRAIN.
- `done`, out, 1: one-cycle pulse when a scan's last beat has been accepted.

## Operation
- **Output slot rule:** the slot is free when `!d_valid || d_ready`. A load happens only when the slot is free.
  - While `d_valid`=1 and `d_ready`=0, `d` and `d_idx` are held stable.
- **IDLE, `mode`=0:** on each edge with the slot free, load `d` ← input[`sel`], `d_idx` ← `sel`, `d_valid` ← 1.
  - If `sel` ≥ N, load `d` ← 0 and `d_idx` ← `sel`.
- **IDLE, `mode`=1:**
  - With no `start`, there are no new loads. An existing beat is held until accepted, then `d_valid` ← 0.
  - When `start`=1 and the slot is free, load input[0] with `d_idx`=0, set the index counter to 1, and go to SCAN.
  - When `start`=1 but the slot is not free, the start is held pending until the slot frees; `start` need not stay asserted.
- **SCAN:** on each edge with the slot free, load input[idx] and set `d_idx` ← idx.
  - If idx = N-1, go to DRAIN; otherwise idx ← idx+1.
  - `din` is sampled per beat, not snapshotted at start.
- **DRAIN:** on the edge where the final beat is accepted, clear `d_valid`, pulse `done`=1 for exactly one cycle, and go to IDLE.
- **Ignored inputs:** `start` in SCAN or DRAIN is ignored. `mode`/`sel` changes during SCAN or DRAIN are ignored.
- **Reset (any state, mid-scan included):** state = IDLE, idx = 0, `d`=0, `d_idx`=0, `d_valid`=0, `busy`=0, `done`=0. Any pending start is discarded.

## Timing
- **Manual latency:** 1 cycle. `sel` stable before edge t → `d` valid after edge t.
- **Manual throughput:** with `d_ready`=1, `d` tracks `sel` one cycle late, every cycle.
- **Scan timing:**
  - `start` sampled at edge t (slot free) → beat 0 is valid after edge t.
  - With `d_ready` held high, beat k is valid after edge t+k.
  - The last beat is accepted at edge t+N, which is also when `done` goes high; `done` drops at edge t+N+1.
- **Back-pressure:** each cycle with `d_ready`=0 extends the scan by exactly one cycle. No beat is dropped or duplicated.
- **`busy`:** high from the edge after start acceptance through the edge that raises `done`.

## Structure
- **Package `scan_mux_pkg`:** the state enum (IDLE, SCAN, DRAIN) and the helper `sel_width(n)`.
- **Sub-module `mux_n_to_1`:** purely combinational. Parameters WIDTH and N; flat `din`, `sel`, output `y`; outputs zero for `sel` ≥ N.
  - One instance is fed by `sel` or idx depending on state.
- **Top level:** FSM, index counter, and output register/handshake only.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-scan (N=32, beat 5 pending) → next cycle `d`=0, `d_idx`=0, `d_valid`=0, `busy`=0, `done`=0; state IDLE.
- **Manual select:** WIDTH=16, N=32, input[10]=`16'b0100001000001101`, `sel`=10, `d_ready`=1 → one cycle later `d`=`16'b0100001000001101`, `d_idx`=10.
  - Then `sel`=25 with input[25]=`16'b0000100111100111` → next cycle `d` equals that word, `d_idx`=25.
- **Full scan:** N=32, input[i]=i, `d_ready`=1, `start` pulse at cycle 0 → 32 consecutive beats with `d_idx`=0..31 and `d`=0..31, `done` high for exactly one cycle, then `busy`=0.
- **Back-pressure:** during a scan, drop `d_ready` for 3 cycles at beat 7 → `d`=7 held for 4 cycles, the following beat is 8, the scan completes 3 cycles later, and there are no gaps or repeats.
- **Non-power-of-two N:** N=5, WIDTH=8, manual `sel`=6 → `d`=0, `d_idx`=6.
  - A scan emits indices 0..4, then `done`.
- **Ignored start:** `start` re-pulsed at beat 10 of a scan → ignored; exactly one `done` after beat 31.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared state encoding and select-width helper for scan_mux_reg
package scan_mux_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_mux_reg_mux_n_to_1.sv
// mux_n_to_1: combinational N-to-1 word mux, zero for out-of-range selects
module mux_n_to_1 #(
    parameter int WIDTH = 16,
    parameter int N     = 32,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++)
            if (sel == SEL_W'(i)) y = din[i*WIDTH +: WIDTH];
    end

endmodule

// File: rtl/scan_mux_reg.sv
// scan_mux_reg: registered N-to-1 mux with valid/ready output and automatic index scan
module scan_mux_reg
    import scan_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 32,
    parameter int SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    input  logic               start,
    output logic [WIDTH-1:0]   d,
    output logic [SEL_W-1:0]   d_idx,
    output logic               d_valid,
    input  logic               d_ready,
    output logic               busy,
    output logic               done
);

    state_t           state;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] mux_sel;
    logic [WIDTH-1:0] y;
    logic             pend;
    logic             free;

    assign free    = !d_valid || d_ready;
    assign busy    = (state != IDLE);
    assign mux_sel = (state == IDLE) ? (mode ? '0 : sel) : idx;

    mux_n_to_1 #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) u_mux (
        .din (din),
        .sel (mux_sel),
        .y   (y)
    );

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            pend    <= 1'b0;
            d       <= '0;
            d_idx   <= '0;
            d_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!mode) begin
                        pend <= 1'b0;
                        if (free) begin
                            d       <= y;
                            d_idx   <= sel;
                            d_valid <= 1'b1;
                        end
                    end else if (start || pend) begin
                        // a start seen while the slot is busy waits here until the beat drains
                        if (free) begin
                            d       <= y;
                            d_idx   <= '0;
                            d_valid <= 1'b1;
                            idx     <= SEL_W'(1);
                            pend    <= 1'b0;
                            state   <= SCAN;
                        end else begin
                            pend <= 1'b1;
                        end
                    end else if (d_ready) begin
                        d_valid <= 1'b0;
                    end
                end
                SCAN: begin
                    if (free) begin
                        d       <= y;
                        d_idx   <= idx;
                        d_valid <= 1'b1;
                        if (idx == SEL_W'(N - 1)) state <= DRAIN;
                        else idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (d_ready) begin
                        d_valid <= 1'b0;
                        done    <= 1'b1;
                        idx     <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_mux_reg.sv
// tb_scan_mux_reg: directed scoreboard bench for scan_mux_reg (N=32 and N=5 instances)
module tb_scan_mux_reg;

    typedef struct {
        logic [4:0]  idx;
        logic [15:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [511:0]  din = '0;
    logic [4:0]    sel = '0;
    logic          mode = 1'b0;
    logic          start = 1'b0;
    logic          d_ready = 1'b1;
    logic [15:0]   d;
    logic [4:0]    d_idx;
    logic          d_valid, busy, done;

    logic [39:0]   din5 = '0;
    logic [2:0]    sel5 = '0;
    logic          mode5 = 1'b0;
    logic          start5 = 1'b0;
    logic          ready5 = 1'b1;
    logic [7:0]    d5;
    logic [2:0]    idx5;
    logic          valid5, busy5, done5;

    beat_t q[$];
    int    n_assert = 0;
    int    n_fail = 0;
    int    done_cyc, done_cnt;

    always #5 clk = ~clk;

    scan_mux_reg dut (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .start(start),
        .d(d), .d_idx(d_idx), .d_valid(d_valid), .d_ready(d_ready), .busy(busy), .done(done)
    );

    scan_mux_reg #(.WIDTH(8), .N(5)) dut5 (
        .clk(clk), .rst(rst), .din(din5), .sel(sel5), .mode(mode5), .start(start5),
        .d(d5), .d_idx(idx5), .d_valid(valid5), .d_ready(ready5), .busy(busy5), .done(done5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // a beat is accepted at the coming edge when valid and ready are both high now
    task automatic tick();
        beat_t e;
        if (d_valid && d_ready) begin
            check("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("sb_idx", 32'(d_idx), 32'(e.idx));
                check("sb_data", 32'(d), 32'(e.data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [15:0] v);
        beat_t e;
        e.idx  = 5'(i);
        e.data = v;
        q.push_back(e);
    endtask

    task automatic run_scan(input int stall_at, input int ignore_at, output int dc, output int dn);
        int  c;
        bit  st, ig;
        for (int i = 0; i < 32; i++) push(i, din[i*16 +: 16]);
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("scan_first_idx", 32'(d_idx), 32'd0);
        check("scan_first_valid", 32'(d_valid), 32'd1);
        check("scan_busy", 32'(busy), 32'd1);
        c = 0; dc = -1; dn = 0; st = 0; ig = 0;
        while (c < 120) begin
            tick();
            c++;
            if (done) begin
                dn++;
                if (dc < 0) dc = c;
            end
            if (!busy && !done) break;
            if (!ig && d_valid && 32'(d_idx) == ignore_at) begin
                start = 1'b1;
                ig = 1;
            end else start = 1'b0;
            if (!st && d_valid && 32'(d_idx) == stall_at) begin
                st = 1;
                d_ready = 1'b0;
                repeat (3) begin
                    tick();
                    c++;
                    check("hold_d", 32'(d), 32'(stall_at));
                    check("hold_idx", 32'(d_idx), 32'(stall_at));
                end
                d_ready = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) din[i*16 +: 16] = 16'(i);
        for (int i = 0; i < 5; i++) din5[i*8 +: 8] = 8'hA0 + 8'(i);
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(d_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        din[10*16 +: 16] = 16'b0100001000001101;
        din[25*16 +: 16] = 16'b0000100111100111;
        sel = 5'd10;
        push(10, 16'b0100001000001101);
        tick();
        check("man10_d", 32'(d), 32'(16'b0100001000001101));
        check("man10_idx", 32'(d_idx), 32'd10);
        check("man10_valid", 32'(d_valid), 32'd1);
        sel = 5'd25;
        push(25, 16'b0000100111100111);
        tick();
        check("man25_d", 32'(d), 32'(16'b0000100111100111));
        check("man25_idx", 32'(d_idx), 32'd25);
        mode = 1'b1;
        tick();
        check("idle_scan_novalid", 32'(d_valid), 32'd0);
        din[10*16 +: 16] = 16'd10;
        din[25*16 +: 16] = 16'd25;

        run_scan(-1, 10, done_cyc, done_cnt);
        check("full_done_cnt", 32'(done_cnt), 32'd1);
        check("full_done_cyc", 32'(done_cyc), 32'd32);
        check("full_busy_after", 32'(busy), 32'd0);
        check("full_valid_after", 32'(d_valid), 32'd0);
        check("full_sb_empty", 32'(q.size()), 32'd0);

        run_scan(7, -1, done_cyc, done_cnt);
        check("bp_done_cnt", 32'(done_cnt), 32'd1);
        check("bp_done_cyc", 32'(done_cyc), 32'd35);
        check("bp_sb_empty", 32'(q.size()), 32'd0);

        for (int i = 0; i < 32; i++) push(i, din[i*16 +: 16]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40 && !(d_valid && d_idx == 5'd5); k++) tick();
        check("mid_beat5", 32'(d_idx), 32'd5);
        d_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        q.delete();
        check("mid_rst_d", 32'(d), 32'd0);
        check("mid_rst_idx", 32'(d_idx), 32'd0);
        check("mid_rst_valid", 32'(d_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        tick();
        check("post_rst_valid", 32'(d_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        d_ready = 1'b1;

        sel5 = 3'd6;
        tick();
        check("n5_oor_d", 32'(d5), 32'd0);
        check("n5_oor_idx", 32'(idx5), 32'd6);
        mode5 = 1'b1;
        tick();
        check("n5_idle_valid", 32'(valid5), 32'd0);
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("n5_scan_idx", 32'(idx5), 32'(k));
            check("n5_scan_d", 32'(d5), 32'(8'hA0 + 8'(k)));
            check("n5_scan_done_low", 32'(done5), 32'd0);
            tick();
        end
        check("n5_done", 32'(done5), 32'd1);
        check("n5_busy_at_done", 32'(busy5), 32'd0);
        tick();
        check("n5_done_drop", 32'(done5), 32'd0);
        check("n5_valid_end", 32'(valid5), 32'd0);

        check("final_sb_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
